// File: rtl/connect4_pkg.sv
// connect4_pkg: shared definitions for the Connect4 turn controller.
//   - controller state encodings (WAIT_INPUT/DROP/CHECK/GAME_OVER)
//   - game status codes (PLAYING/P1_WIN/P2_WIN/DRAW)
//   - win checker result codes
//   - idle column code and default board geometry
package connect4_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] status_t;

    localparam state_t ST_WAIT_INPUT = 2'b00;
    localparam state_t ST_DROP       = 2'b01;
    localparam state_t ST_CHECK      = 2'b10;
    localparam state_t ST_GAME_OVER  = 2'b11;

    localparam status_t STATUS_PLAYING = 2'b00;
    localparam status_t STATUS_P1_WIN  = 2'b01;
    localparam status_t STATUS_P2_WIN  = 2'b10;
    localparam status_t STATUS_DRAW    = 2'b11;

    typedef enum logic [1:0] {
        WIN_NONE    = 2'b00,
        WIN_P1      = 2'b01,
        WIN_P2      = 2'b10,
        WIN_ILLEGAL = 2'b11
    } win_code_e;

    localparam logic [2:0] COL_IDLE = 3'b111;

    localparam int unsigned NUM_COLS_DEF  = 4;
    localparam int unsigned MAX_MOVES_DEF = 16;

    // True when col addresses a playable column.
    function automatic logic col_in_range(input logic [2:0] col, input int unsigned num_cols);
        return {29'd0, col} < num_cols;
    endfunction

endpackage

// File: rtl/connect4_sel_detect.sv
// connect4_sel_detect: turns the raw player column input into single selection events.
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   in_column  in   player column select, COL_IDLE when nothing is pressed
//   sel_event  out  one cycle high on a transition out of idle
//   sel_col    out  column belonging to sel_event
module connect4_sel_detect
    import connect4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] in_column,
    output logic       sel_event,
    output logic [2:0] sel_col
);

    logic [2:0] col_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= COL_IDLE;
        end else begin
            col_q <= in_column;
        end
    end

    // Only the first cycle of a held selection counts.
    assign sel_event = (in_column != COL_IDLE) && (col_q == COL_IDLE);
    assign sel_col   = in_column;

endmodule

// File: rtl/connect4_turn_controller.sv
// connect4_turn_controller: sequences turns for the Connect4 board datapath.
// Optional feature macro: TURN_TIMEOUT_EN (per-turn timer that forfeits an idle turn).
//   clk              in   system clock
//   reset            in   asynchronous active-low reset
//   in_column        in   player column select (3'b111 idle)
//   in_new_game      in   restart request (WAIT_INPUT / GAME_OVER only)
//   drop_done        in   datapath pulse: piece landed
//   drop_full        in   datapath pulse: column full, nothing written
//   win_in           in   win checker result, sampled in CHECK
//   drop_req         out  level request to the datapath
//   drop_column      out  column of the pending drop (3'b111 when idle)
//   drop_player      out  owner of the pending drop
//   board_clear      out  one-cycle board clear pulse
//   playerTurn       out  player whose turn it is
//   throw_again      out  current player must select again
//   oinvalid_column  out  one-cycle pulse on a rejected selection
//   out_game_status  out  playing / P1 won / P2 won / draw
//   current_state    out  controller state
//   timeout          out  one-cycle pulse when a turn is forfeited
module connect4_turn_controller
    import connect4_pkg::*;
#(
    parameter int unsigned NUM_COLS  = NUM_COLS_DEF,
    parameter int unsigned MAX_MOVES = MAX_MOVES_DEF
`ifdef TURN_TIMEOUT_EN
    ,
    parameter int unsigned TURN_TIMEOUT = 1000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] in_column,
    input  logic       in_new_game,
    input  logic       drop_done,
    input  logic       drop_full,
    input  logic [1:0] win_in,
    output logic       drop_req,
    output logic [2:0] drop_column,
    output logic       drop_player,
    output logic       board_clear,
    output logic       playerTurn,
    output logic       throw_again,
    output logic       oinvalid_column,
    output logic [1:0] out_game_status,
    output logic [1:0] current_state,
    output logic       timeout
);

    localparam int unsigned MC_W = $clog2(MAX_MOVES + 1);

    logic            sel_event;
    logic [2:0]      sel_col;

    state_t          state_q, state_d;
    logic            player_q, player_d;
    logic            drop_req_q, drop_req_d;
    logic [2:0]      drop_col_q, drop_col_d;
    logic            drop_player_q, drop_player_d;
    logic            board_clear_q, board_clear_d;
    logic            throw_q, throw_d;
    logic            invalid_q, invalid_d;
    status_t         status_q, status_d;
    logic [MC_W-1:0] move_count_q, move_count_d;
    logic            timeout_q, timeout_d;

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned TW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    logic [TW-1:0]   timer_q, timer_d;
`endif

    connect4_sel_detect u_sel_detect (
        .clk       (clk),
        .reset     (reset),
        .in_column (in_column),
        .sel_event (sel_event),
        .sel_col   (sel_col)
    );

    always_comb begin
        state_d       = state_q;
        player_d      = player_q;
        drop_req_d    = drop_req_q;
        drop_col_d    = drop_col_q;
        drop_player_d = drop_player_q;
        board_clear_d = 1'b0;
        throw_d       = throw_q;
        invalid_d     = 1'b0;
        status_d      = status_q;
        move_count_d  = move_count_q;
        timeout_d     = 1'b0;
`ifdef TURN_TIMEOUT_EN
        timer_d       = timer_q;
`endif

        case (state_q)
            ST_WAIT_INPUT: begin
                if (in_new_game) begin
                    // Restart wins over a coincident selection.
                    board_clear_d = 1'b1;
                    move_count_d  = '0;
                    player_d      = 1'b0;
                    status_d      = STATUS_PLAYING;
                    throw_d       = 1'b0;
`ifdef TURN_TIMEOUT_EN
                    timer_d       = '0;
`endif
                end else if (sel_event) begin
`ifdef TURN_TIMEOUT_EN
                    timer_d = '0;
`endif
                    if (!col_in_range(sel_col, NUM_COLS)) begin
                        invalid_d = 1'b1;
                        throw_d   = 1'b1;
                    end else begin
                        drop_col_d    = sel_col;
                        drop_player_d = player_q;
                        drop_req_d    = 1'b1;
                        state_d       = ST_DROP;
                    end
                end
`ifdef TURN_TIMEOUT_EN
                else if (timer_q == TW'(TURN_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    player_d  = ~player_q;
                    throw_d   = 1'b0;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
`endif
            end

            ST_DROP: begin
                // drop_done takes priority over a simultaneous drop_full.
                if (drop_done) begin
                    drop_req_d = 1'b0;
                    drop_col_d = COL_IDLE;
                    throw_d    = 1'b0;
                    if (move_count_q != MC_W'(MAX_MOVES)) begin
                        move_count_d = move_count_q + MC_W'(1);
                    end
                    state_d = ST_CHECK;
                end else if (drop_full) begin
                    drop_req_d = 1'b0;
                    drop_col_d = COL_IDLE;
                    invalid_d  = 1'b1;
                    throw_d    = 1'b1;
                    state_d    = ST_WAIT_INPUT;
                end
            end

            ST_CHECK: begin
                if (win_in == WIN_P1) begin
                    status_d = STATUS_P1_WIN;
                    state_d  = ST_GAME_OVER;
                end else if (win_in == WIN_P2) begin
                    status_d = STATUS_P2_WIN;
                    state_d  = ST_GAME_OVER;
                end else if (move_count_q == MC_W'(MAX_MOVES)) begin
                    // WIN_ILLEGAL falls through here like WIN_NONE.
                    status_d = STATUS_DRAW;
                    state_d  = ST_GAME_OVER;
                end else begin
                    player_d = ~player_q;
                    state_d  = ST_WAIT_INPUT;
                end
            end

            default: begin
                if (in_new_game) begin
                    board_clear_d = 1'b1;
                    move_count_d  = '0;
                    player_d      = 1'b0;
                    status_d      = STATUS_PLAYING;
                    throw_d       = 1'b0;
                    state_d       = ST_WAIT_INPUT;
                end
            end
        endcase

`ifdef TURN_TIMEOUT_EN
        // Every turn starts with a fresh timer.
        if (state_d == ST_WAIT_INPUT && state_q != ST_WAIT_INPUT) begin
            timer_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_WAIT_INPUT;
            player_q      <= 1'b0;
            drop_req_q    <= 1'b0;
            drop_col_q    <= COL_IDLE;
            drop_player_q <= 1'b0;
            board_clear_q <= 1'b0;
            throw_q       <= 1'b0;
            invalid_q     <= 1'b0;
            status_q      <= STATUS_PLAYING;
            move_count_q  <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            player_q      <= player_d;
            drop_req_q    <= drop_req_d;
            drop_col_q    <= drop_col_d;
            drop_player_q <= drop_player_d;
            board_clear_q <= board_clear_d;
            throw_q       <= throw_d;
            invalid_q     <= invalid_d;
            status_q      <= status_d;
            move_count_q  <= move_count_d;
            timeout_q     <= timeout_d;
        end
    end

`ifdef TURN_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign drop_req        = drop_req_q;
    assign drop_column     = drop_col_q;
    assign drop_player     = drop_player_q;
    assign board_clear     = board_clear_q;
    assign playerTurn      = player_q;
    assign throw_again     = throw_q;
    assign oinvalid_column = invalid_q;
    assign out_game_status = status_q;
    assign current_state   = state_q;

endmodule

// File: tb/tb_connect4_turn_controller.sv
// tb_connect4_turn_controller: self-checking bench for connect4_turn_controller.
// Moves are applied at transaction level; a small game model (whose turn, how many
// pieces landed, who won) supplies every expected value.
module tb_connect4_turn_controller;

    localparam int RESP_DONE = 0;
    localparam int RESP_FULL = 1;
    localparam int RESP_BOTH = 2;
    localparam logic [2:0] IDLE = 3'b111;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] in_column;
    logic       in_new_game, drop_done, drop_full;
    logic [1:0] win_in;
    logic       drop_req, drop_player, board_clear, playerTurn, throw_again;
    logic       oinvalid_column, timeout;
    logic [2:0] drop_column;
    logic [1:0] out_game_status, current_state;

    always #5 clk = ~clk;

`ifdef TURN_TIMEOUT_EN
    connect4_turn_controller #(.TURN_TIMEOUT(8)) dut (
`else
    connect4_turn_controller dut (
`endif
        .clk             (clk),
        .reset           (reset),
        .in_column       (in_column),
        .in_new_game     (in_new_game),
        .drop_done       (drop_done),
        .drop_full       (drop_full),
        .win_in          (win_in),
        .drop_req        (drop_req),
        .drop_column     (drop_column),
        .drop_player     (drop_player),
        .board_clear     (board_clear),
        .playerTurn      (playerTurn),
        .throw_again     (throw_again),
        .oinvalid_column (oinvalid_column),
        .out_game_status (out_game_status),
        .current_state   (current_state),
        .timeout         (timeout)
    );

    int checks = 0;
    int errors = 0;

    // Game model: turn owner, pieces landed, result (0 playing, 1/2 winner, 3 draw).
    int m_player, m_count, m_status, m_throw;

    typedef struct {
        logic [2:0] col;
        int         resp;
        logic [1:0] win;
        int         exp_player;
        int         exp_status;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_player = 0;
        m_count  = 0;
        m_status = 0;
        m_throw  = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_turn"}, 32'(playerTurn), m_player);
        chk({tag, "_status"}, 32'(out_game_status), m_status);
        chk({tag, "_throw"}, 32'(throw_again), m_throw);
        chk({tag, "_count"}, 32'(dut.move_count_q), m_count);
        chk({tag, "_state"}, 32'(current_state), (m_status != 0) ? 3 : 0);
    endtask

    task automatic new_game();
        in_new_game = 1'b1;
        tick();
        in_new_game = 1'b0;
        chk("newgame_clear", 32'(board_clear), 1);
        model_reset();
        check_model("newgame");
        tick();
        chk("newgame_clear_end", 32'(board_clear), 0);
    endtask

    task automatic do_move(input logic [2:0] col, input int resp, input logic [1:0] win,
                           input int wait_cyc, input int stall);
        repeat (wait_cyc) tick();
        in_column = col;
        tick();
        in_column = IDLE;
        if (m_status != 0) begin
            chk("over_noreq", 32'(drop_req), 0);
            chk("over_state", 32'(current_state), 3);
            tick();
        end else if (col >= 3'd4) begin
            chk("bad_invalid", 32'(oinvalid_column), 1);
            chk("bad_throw", 32'(throw_again), 1);
            chk("bad_noreq", 32'(drop_req), 0);
            m_throw = 1;
            tick();
            chk("bad_invalid_end", 32'(oinvalid_column), 0);
        end else begin
            chk("req", 32'(drop_req), 1);
            chk("req_col", 32'(drop_column), 32'(col));
            chk("req_player", 32'(drop_player), m_player);
            chk("req_state", 32'(current_state), 1);
            repeat (stall) begin
                tick();
                chk("req_held", 32'(drop_req), 1);
            end
            if (resp == RESP_FULL) begin
                drop_full = 1'b1;
                tick();
                drop_full = 1'b0;
                chk("full_noreq", 32'(drop_req), 0);
                chk("full_col", 32'(drop_column), 7);
                chk("full_invalid", 32'(oinvalid_column), 1);
                m_throw = 1;
                tick();
                chk("full_invalid_end", 32'(oinvalid_column), 0);
            end else begin
                drop_done = 1'b1;
                drop_full = (resp == RESP_BOTH);
                tick();
                drop_done = 1'b0;
                drop_full = 1'b0;
                chk("done_state", 32'(current_state), 2);
                chk("done_noreq", 32'(drop_req), 0);
                chk("done_col", 32'(drop_column), 7);
                chk("done_noinvalid", 32'(oinvalid_column), 0);
                m_throw = 0;
                m_count++;
                win_in = win;
                tick();
                win_in = 2'b00;
                if (win == 2'b01)      m_status = 1;
                else if (win == 2'b10) m_status = 2;
                else if (m_count == 16) m_status = 3;
                else                   m_player ^= 1;
            end
        end
        check_model("move");
    endtask

    initial begin
        vt[0] = '{3'd0, RESP_DONE, 2'b00, 1, 0};
        vt[1] = '{3'd5, RESP_DONE, 2'b00, 1, 0};
        vt[2] = '{3'd2, RESP_DONE, 2'b00, 0, 0};
        vt[3] = '{3'd0, RESP_FULL, 2'b00, 0, 0};
        vt[4] = '{3'd3, RESP_BOTH, 2'b00, 1, 0};
        vt[5] = '{3'd1, RESP_DONE, 2'b11, 0, 0};
        vt[6] = '{3'd0, RESP_DONE, 2'b01, 0, 1};
        vt[7] = '{3'd1, RESP_DONE, 2'b00, 0, 1};

        reset = 1'b0;
        in_column = IDLE;
        in_new_game = 1'b0;
        drop_done = 1'b0;
        drop_full = 1'b0;
        win_in = 2'b00;
        model_reset();
        #12;
        chk("rst_req", 32'(drop_req), 0);
        chk("rst_col", 32'(drop_column), 7);
        chk("rst_player", 32'(drop_player), 0);
        chk("rst_clear", 32'(board_clear), 0);
        chk("rst_invalid", 32'(oinvalid_column), 0);
        chk("rst_timeout", 32'(timeout), 0);
        check_model("rst");
        reset = 1'b1;
        tick();

        // Table: test-plan game ending in a P1 win, then a selection after game over.
        for (int i = 0; i < 8; i++) begin
            do_move(vt[i].col, vt[i].resp, vt[i].win, 0, 0);
            chk("vec_player", 32'(playerTurn), vt[i].exp_player);
            chk("vec_status", 32'(out_game_status), vt[i].exp_status);
        end
        new_game();

        // Holding a column gives exactly one drop.
        in_column = 3'd1;
        tick();
        chk("hold_req", 32'(drop_req), 1);
        drop_done = 1'b1;
        tick();
        drop_done = 1'b0;
        tick();
        m_count++;
        m_player ^= 1;
        repeat (3) tick();
        chk("hold_noreq", 32'(drop_req), 0);
        check_model("hold");
        in_column = IDLE;
        tick();

        // Restart coinciding with a selection: restart wins.
        in_column = 3'd2;
        in_new_game = 1'b1;
        tick();
        in_column = IDLE;
        in_new_game = 1'b0;
        chk("coin_clear", 32'(board_clear), 1);
        chk("coin_noreq", 32'(drop_req), 0);
        model_reset();
        check_model("coin");
        tick();
        chk("coin_noreq2", 32'(drop_req), 0);

        // Restart ignored in DROP and in CHECK.
        in_column = 3'd0;
        tick();
        in_column = IDLE;
        in_new_game = 1'b1;
        tick();
        chk("ng_drop_state", 32'(current_state), 1);
        chk("ng_drop_clear", 32'(board_clear), 0);
        chk("ng_drop_req", 32'(drop_req), 1);
        in_new_game = 1'b0;
        drop_done = 1'b1;
        tick();
        drop_done = 1'b0;
        in_new_game = 1'b1;
        tick();
        in_new_game = 1'b0;
        chk("ng_check_clear", 32'(board_clear), 0);
        m_count++;
        m_player ^= 1;
        check_model("ng_check");

        // Sixteen landed pieces without a winner is a draw.
        new_game();
        for (int i = 0; i < 16; i++) do_move(3'(i % 4), RESP_DONE, 2'b00, 0, 0);
        chk("draw_status", 32'(out_game_status), 3);
        chk("draw_count", 32'(dut.move_count_q), 16);
        do_move(3'd2, RESP_DONE, 2'b00, 0, 0);

        // Asynchronous reset in the middle of a P2 drop.
        new_game();
        do_move(3'd0, RESP_DONE, 2'b00, 0, 0);
        in_column = 3'd1;
        tick();
        in_column = IDLE;
        chk("mid_req", 32'(drop_req), 1);
        chk("mid_player", 32'(drop_player), 1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_req", 32'(drop_req), 0);
        chk("arst_col", 32'(drop_column), 7);
        chk("arst_player", 32'(drop_player), 0);
        check_model("arst");
        #2;
        reset = 1'b1;
        tick();

`ifdef TURN_TIMEOUT_EN
        in_new_game = 1'b1;
        tick();
        in_new_game = 1'b0;
        model_reset();
        repeat (7) begin
            tick();
            chk("to_quiet", 32'(timeout), 0);
        end
        tick();
        chk("to_pulse", 32'(timeout), 1);
        m_player ^= 1;
        check_model("to");
        tick();
        chk("to_pulse_end", 32'(timeout), 0);
`else
        repeat (20) tick();
        chk("no_timeout", 32'(timeout), 0);
        check_model("idle");
`endif

        // Random games against the model.
        new_game();
        for (int n = 0; n < 300; n++) begin
            int r, rr, rw;
            logic [2:0] col;
            int resp;
            logic [1:0] win;
            if (m_status != 0 && $urandom_range(0, 2) == 0) new_game();
            r = $urandom_range(0, 9);
            col = (r < 8) ? 3'(r % 4) : 3'($urandom_range(4, 6));
            rr = $urandom_range(0, 9);
            resp = (rr < 7) ? RESP_DONE : (rr < 9) ? RESP_FULL : RESP_BOTH;
            rw = $urandom_range(0, 19);
            win = (rw == 0) ? 2'b01 : (rw == 1) ? 2'b10 : (rw == 2) ? 2'b11 : 2'b00;
            do_move(col, resp, win, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
